// File: rtl/collision_ctrl_pkg.sv
// Shared encodings for the collision recovery sequencer and its collision detector.
package collision_ctrl_pkg;

    // State encoding, also exported on state_o for LEDs/debug
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StDrive   = 3'd1,
        StBrake   = 3'd2,
        StReverse = 3'd3,
        StTurn    = 3'd4,
        StSettle  = 3'd5,
        StFault   = 3'd6
    } state_e;

    // Collision detector flag levels
    localparam logic ColDrive = 1'b1;
    localparam logic ColStop  = 1'b0;

    // Motor patterns, bit order {l_fwd, l_rev, r_fwd, r_rev}
    localparam logic [3:0] MotFwd  = 4'b1010;
    localparam logic [3:0] MotRev  = 4'b0101;
    localparam logic [3:0] MotPivR = 4'b1001;
    localparam logic [3:0] MotPivL = 4'b0110;
    localparam logic [3:0] MotOff  = 4'b0000;

    // Moore decode of a state into H-bridge lines; never fwd and rev on one motor
    function automatic logic [3:0] motor_pattern(state_e st, logic pivot_left);
        logic [3:0] pat;
        pat = MotOff;
        case (st)
            StDrive:   pat = MotFwd;
            StReverse: pat = MotRev;
            StTurn:    pat = pivot_left ? MotPivL : MotPivR;
            default:   pat = MotOff;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Up-counter with synchronous clear and a done flag against a runtime terminal value.
module phase_timer #(
    parameter int unsigned TIMER_W = 28
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [TIMER_W-1:0] limit_i,
    output logic               done_o
);

    logic [TIMER_W-1:0] cnt_q;

    // Count enabled cycles; clear wins over count
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + TIMER_W'(1);
        end
    end

    // limit_i is N-1, so a phase of N cycles ends on its last cycle
    assign done_o = en_i && (cnt_q == limit_i);

endmodule

// File: rtl/collision_recovery_ctrl.sv
// Motion sequencer: drive forward, and on collision brake/reverse/pivot/settle,
// escalating to a latched fault after too many collisions inside a DRIVE window.
module collision_recovery_ctrl
    import collision_ctrl_pkg::*;
#(
    parameter int unsigned BRAKE_CYCLES   = 5_000_000,
    parameter int unsigned REVERSE_CYCLES = 25_000_000,
    parameter int unsigned TURN_CYCLES    = 15_000_000,
    parameter int unsigned SETTLE_CYCLES  = 2_500_000,
    // A 2-bit saturating count can only exceed 2, so 2 is the largest usable value
    parameter int unsigned MAX_RETRIES    = 2,
    parameter int unsigned WINDOW_CYCLES  = 250_000_000,
    parameter int unsigned TIMER_W        = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       col_ok,
    output logic       l_fwd,
    output logic       l_rev,
    output logic       r_fwd,
    output logic       r_rev,
    output logic       fault,
    output logic [2:0] state_o,
    output logic [1:0] retry_cnt
);

    if (MAX_RETRIES > 2) begin : g_bad_retries
        $error("MAX_RETRIES must be <= 2 so a 2-bit retry count can exceed it");
    end
    if (BRAKE_CYCLES == 0 || REVERSE_CYCLES == 0 || TURN_CYCLES == 0 ||
        SETTLE_CYCLES == 0 || WINDOW_CYCLES == 0) begin : g_bad_zero
        $error("all *_CYCLES parameters must be at least 1");
    end
    if (TIMER_W < 32 && (((BRAKE_CYCLES - 1) >> TIMER_W) != 0 ||
        ((REVERSE_CYCLES - 1) >> TIMER_W) != 0 || ((TURN_CYCLES - 1) >> TIMER_W) != 0 ||
        ((SETTLE_CYCLES - 1) >> TIMER_W) != 0 ||
        ((WINDOW_CYCLES - 1) >> TIMER_W) != 0)) begin : g_bad_width
        $error("TIMER_W too narrow for the configured cycle counts");
    end

    localparam logic [1:0] MaxRetry = 2'(MAX_RETRIES);

    state_e             state_q, state_d;
    logic [1:0]         retry_q;
    logic               turn_dir_q, pivot_left_q, fault_q;
    logic [3:0]         motor_q;
    logic [TIMER_W-1:0] ph_limit;
    logic               ph_done, ph_en, ph_clr;
    logic               win_done, win_en, win_clr;
    logic               collision;

    // Terminal count for the timed state currently occupied
    always_comb begin
        ph_limit = '0;
        case (state_q)
            StBrake:   ph_limit = TIMER_W'(BRAKE_CYCLES - 1);
            StReverse: ph_limit = TIMER_W'(REVERSE_CYCLES - 1);
            StTurn:    ph_limit = TIMER_W'(TURN_CYCLES - 1);
            StSettle:  ph_limit = TIMER_W'(SETTLE_CYCLES - 1);
            default:   ph_limit = '0;
        endcase
    end

    assign ph_en  = (state_q == StBrake) || (state_q == StReverse) ||
                    (state_q == StTurn) || (state_q == StSettle);
    assign ph_clr = (state_d != state_q);

    // Window restarts on every BRAKE entry and on its own expiry
    assign win_en  = enable && (state_q == StDrive);
    assign win_clr = ((state_d == StBrake) && (state_q != StBrake)) || win_done;

    // A collision is a stop flag in DRIVE or at the end of SETTLE
    assign collision = enable && (col_ok == ColStop) &&
                       ((state_q == StDrive) || ((state_q == StSettle) && ph_done));

    // Next-state logic; enable=0 overrides every timed transition
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:    state_d = StDrive;
                StDrive:   if (col_ok == ColStop) state_d = StBrake;
                StBrake:   if (ph_done) state_d = (retry_q > MaxRetry) ? StFault : StReverse;
                StReverse: if (ph_done) state_d = StTurn;
                StTurn:    if (ph_done) state_d = StSettle;
                StSettle:  if (ph_done) state_d = (col_ok == ColDrive) ? StDrive : StBrake;
                StFault:   state_d = StFault;
                default:   state_d = StIdle;
            endcase
        end
    end

    // State, retry bookkeeping and registered Moore outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            retry_q      <= 2'd0;
            turn_dir_q   <= 1'b0;
            pivot_left_q <= 1'b0;
            fault_q      <= 1'b0;
            motor_q      <= MotOff;
        end else begin
            state_q <= state_d;
            fault_q <= (state_d == StFault);
            // pivot_left_q is never updated on a TURN entry, so the old value is current
            motor_q <= motor_pattern(state_d, pivot_left_q);
            if (!enable && (state_q == StFault)) begin
                retry_q <= 2'd0;
            end else if (collision) begin
                // Collision beats a same-cycle window expiry
                retry_q      <= (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
                pivot_left_q <= turn_dir_q;
                turn_dir_q   <= ~turn_dir_q;
            end else if (win_done) begin
                retry_q <= 2'd0;
            end
        end
    end

    phase_timer #(.TIMER_W(TIMER_W)) u_phase_timer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (ph_clr),
        .en_i    (ph_en),
        .limit_i (ph_limit),
        .done_o  (ph_done)
    );

    phase_timer #(.TIMER_W(TIMER_W)) u_window_timer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (win_clr),
        .en_i    (win_en),
        .limit_i (TIMER_W'(WINDOW_CYCLES - 1)),
        .done_o  (win_done)
    );

    assign {l_fwd, l_rev, r_fwd, r_rev} = motor_q;
    assign fault     = fault_q;
    assign state_o   = state_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_collision_recovery_ctrl.sv
// Directed, table-driven bench for collision_recovery_ctrl with short phase lengths.
module tb_collision_recovery_ctrl;

    localparam logic [2:0] SI = 3'd0, SD = 3'd1, SB = 3'd2, SR = 3'd3;
    localparam logic [2:0] ST = 3'd4, SS = 3'd5, SF = 3'd6;

    logic       clk, rst, enable, col_ok;
    logic       l_fwd, l_rev, r_fwd, r_rev, fault;
    logic [2:0] state_o;
    logic [1:0] retry_cnt;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       col;
        int         n;
        logic [2:0] st;
        logic [3:0] mot;
        logic       flt;
        logic [1:0] rc;
    } vec_t;

    vec_t tbl[$];

    collision_recovery_ctrl #(
        .BRAKE_CYCLES   (4),
        .REVERSE_CYCLES (8),
        .TURN_CYCLES    (6),
        .SETTLE_CYCLES  (3),
        .MAX_RETRIES    (2),
        .WINDOW_CYCLES  (100),
        .TIMER_W        (28)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .col_ok    (col_ok),
        .l_fwd     (l_fwd),
        .l_rev     (l_rev),
        .r_fwd     (r_fwd),
        .r_rev     (r_rev),
        .fault     (fault),
        .state_o   (state_o),
        .retry_cnt (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic e, logic c, int n, logic [2:0] s,
                                logic [3:0] m, logic f, logic [1:0] rc);
        vec_t v;
        v.rst = r; v.en = e; v.col = c; v.n = n;
        v.st = s; v.mot = m; v.flt = f; v.rc = rc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [2:0] s, input logic [3:0] m,
                       input logic f, input logic [1:0] rc);
        logic [3:0] mot;
        mot = {l_fwd, l_rev, r_fwd, r_rev};
        checks++;
        if (state_o === s && mot === m && fault === f && retry_cnt === rc) begin
            passed++;
        end else begin
            $display("FAIL %s: got st=%0d mot=%b flt=%b rc=%0d, want st=%0d mot=%b flt=%b rc=%0d",
                     nm, state_o, mot, fault, retry_cnt, s, m, f, rc);
        end
        checks++;
        if (!((l_fwd && l_rev) || (r_fwd && r_rev))) begin
            passed++;
        end else begin
            $display("FAIL %s shoot-through: got mot=%b, want no fwd&rev pair", nm, mot);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
        int k = 0;
        while (state_o !== s && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (state_o === s) passed++;
        else $display("FAIL %s: got st=%0d after %0d cycles, want st=%0d", nm, state_o, k, s);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; col_ok = 1'b1;

        // Reset and first drive, reset mid-DRIVE
        tbl.push_back(mk(1, 0, 1, 2,   SI, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 0, 1, 2,   SI, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 1, 1, 3,   SD, 4'b1010, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1,   SI, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 1, 1, 5,   SD, 4'b1010, 0, 0));
        // First collision: pivot right; col_ok low is ignored in BRAKE/REVERSE
        tbl.push_back(mk(0, 1, 0, 1,   SB, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 1, 0, 3,   SB, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8,   SR, 4'b0101, 0, 1));
        tbl.push_back(mk(0, 1, 1, 6,   ST, 4'b1001, 0, 1));
        tbl.push_back(mk(0, 1, 1, 3,   SS, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 1, 1, 10,  SD, 4'b1010, 0, 1));
        // Second collision: pivot left, obstacle still there at end of SETTLE
        tbl.push_back(mk(0, 1, 0, 1,   SB, 4'b0000, 0, 2));
        tbl.push_back(mk(0, 1, 1, 3,   SB, 4'b0000, 0, 2));
        tbl.push_back(mk(0, 1, 1, 8,   SR, 4'b0101, 0, 2));
        tbl.push_back(mk(0, 1, 1, 6,   ST, 4'b0110, 0, 2));
        tbl.push_back(mk(0, 1, 0, 3,   SS, 4'b0000, 0, 2));
        // Third collision from SETTLE, BRAKE then FAULT, cleared by enable=0
        tbl.push_back(mk(0, 1, 0, 4,   SB, 4'b0000, 0, 3));
        tbl.push_back(mk(0, 1, 1, 3,   SF, 4'b0000, 1, 3));
        tbl.push_back(mk(0, 0, 1, 2,   SI, 4'b0000, 0, 0));
        // Window test: two collisions, then 100 DRIVE cycles clear the count
        tbl.push_back(mk(0, 1, 1, 10,  SD, 4'b1010, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1,   SB, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 1, 1, 3,   SB, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 1, 1, 8,   SR, 4'b0101, 0, 1));
        tbl.push_back(mk(0, 1, 1, 6,   ST, 4'b0110, 0, 1));
        tbl.push_back(mk(0, 1, 1, 3,   SS, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 1, 1, 20,  SD, 4'b1010, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1,   SB, 4'b0000, 0, 2));
        tbl.push_back(mk(0, 1, 1, 3,   SB, 4'b0000, 0, 2));
        tbl.push_back(mk(0, 1, 1, 8,   SR, 4'b0101, 0, 2));
        tbl.push_back(mk(0, 1, 1, 6,   ST, 4'b1001, 0, 2));
        tbl.push_back(mk(0, 1, 1, 3,   SS, 4'b0000, 0, 2));
        tbl.push_back(mk(0, 1, 1, 100, SD, 4'b1010, 0, 2));
        tbl.push_back(mk(0, 1, 1, 5,   SD, 4'b1010, 0, 0));
        // A further collision counts from zero and recovers without FAULT
        tbl.push_back(mk(0, 1, 0, 1,   SB, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 1, 1, 3,   SB, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 1, 1, 8,   SR, 4'b0101, 0, 1));
        tbl.push_back(mk(0, 1, 1, 6,   ST, 4'b0110, 0, 1));
        tbl.push_back(mk(0, 1, 1, 3,   SS, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 1, 1, 3,   SD, 4'b1010, 0, 1));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                rst    = tbl[i].rst;
                enable = tbl[i].en;
                col_ok = tbl[i].col;
                @(negedge clk);
                chk($sformatf("vec%0d.%0d", i, k), tbl[i].st, tbl[i].mot, tbl[i].flt, tbl[i].rc);
            end
        end

        // enable dropped mid-REVERSE: IDLE next cycle, retry count kept
        col_ok = 1'b0;
        @(negedge clk);
        chk("mid_rev_collide", SB, 4'b0000, 1'b0, 2'd2);
        col_ok = 1'b1;
        wait_state(SR, 20, "reach_reverse");
        repeat (2) @(negedge clk);
        chk("mid_rev_hold", SR, 4'b0101, 1'b0, 2'd2);
        enable = 1'b0;
        @(negedge clk);
        chk("mid_rev_disable", SI, 4'b0000, 1'b0, 2'd2);
        enable = 1'b1;
        @(negedge clk);
        chk("reenable_drive", SD, 4'b1010, 1'b0, 2'd2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
